fetch_queue_unit: RTL

//  Instruction-fetch front end: owns the PC, drives the byte address of the

---
 rtl/fetch_queue_unit.sv | 80 ++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the PC, fetches from a combinational imem and queues {pc, inst} for decode.
// Head is visible one cycle after its address was on imem_addr. A full queue with no pop freezes the PC.
module fetch_queue_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [31:0]             imem_addr,
   input  logic [31:0]             imem_inst,
   input  logic                    redirect_valid,
   input  logic [31:0]             redirect_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_inst,
   output logic [31:0]             out_pc,
   output logic [$clog2(DEPTH):0]  out_count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

   fq_entry_t       mem [DEPTH];
   fq_entry_t       head_dat;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [31:0]     pc;
   logic            full;
   logic            pop;
   logic            push;

   assign imem_addr = pc;
   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   // A full queue can still accept when the head leaves on the same edge.
   assign push      = ~redirect_valid & (~full | pop);

   // Head is zeroed when empty so stale entries never leak onto the bus.
   assign head_dat  = out_valid ? mem[rd_ptr] : '0;
   assign out_pc    = head_dat.pc;
   assign out_inst  = head_dat.inst;
   assign out_count = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         // Squash everything in flight, including a head being popped this edge.
         pc     <= {redirect_pc[31:2], 2'b00};
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            pc     <= pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= {pc, imem_inst};
      end
   end

endmodule
